mmio_responder: RTL and testbench
=================================

// Module: mmio_responder
// PURPOSE
//  Memory-mapped I/O responder for the CPU memory interface (mem_cmd/mem_addr); sits beside RAM.
//  RAM answers mem_addr[8]==0. This block answers mem_addr[8]==1: LED, switch and timer registers.
//  Top level gates read_data onto the CPU read bus with read_en, the same way as the RAM tristate.
// PARAMETERS
//  LED_W      8      width of LED output register (ledr)
//  SW_W       8      width of switch input (sw)
//  SYNC_N     2      flop stages in the sw synchronizer (>=2)
//  MREAD      2'b01  mem_cmd encoding for read
//  MWRITE     2'b00  mem_cmd encoding for write; 2'b10/2'b11 = no operation
// PORTS
//  clk         in   1    system clock, all state on rising edge
//  reset       in   1    synchronous, active-high reset
//  mem_cmd     in   2    CPU memory command
//  mem_addr    in   9    CPU address; block selected when mem_addr[8]==1
//  write_data  in   16   CPU write data (datapath out)
//  read_data   out  16   read data to CPU; combinational from current register state
//  read_en     out  1    1 when mem_cmd==MREAD && mem_addr[8]==1 (drive enable for read bus)
//  sw          in   SW_W asynchronous board switches
//  ledr        out  LED_W LED register contents
//  timer_irq   out  1    copy of TSTAT.match (sticky)
// BEHAVIOUR
//  Register map (full 9-bit address decode; all other 0x100-0x1FF: reads 0x0000, writes ignored):
//   0x100 LED   R/W  [LED_W-1:0]; write loads write_data[LED_W-1:0]; read zero-extended
//   0x140 SW    R    synchronized sw, zero-extended; writes ignored
//   0x180 TCNT  R/W  16-bit timer count
//   0x181 TCMP  R/W  16-bit compare value
//   0x182 TCTL  R/W  bit0 EN, bit1 AUTORELOAD; bits[15:2] read 0
//   0x183 TSTAT R/W1C bit0 MATCH; writing 1 to bit0 clears; bits[15:1] read 0
//  Access timing:
//   - Write: commits on the rising edge of every cycle with mem_cmd==MWRITE, mem_addr[8]==1.
//     Multi-cycle holds rewrite the same value, so repeated write is harmless.
//   - Read: zero latency. read_data is valid in the same cycle the address is presented.
//     Reads have no side effects, so the CPU can hold a read for any number of cycles.
//   - read_en=0 -> read_data=16'h0000.
//  Reset (reset=1 at edge): ledr=0, TCNT=0, TCMP=16'hFFFF, TCTL=0, MATCH=0, timer_irq=0.
//   - Synchronizer flops are cleared, so SW reads 0 until SYNC_N edges after reset deasserts.
//   - Reset overrides every simultaneous write or timer event.
//  sw synchronizer: SYNC_N-stage shift; a sw change is visible at 0x140 after SYNC_N edges.
//  Timer, per edge with EN=1:
//   - if TCNT==TCMP: MATCH<=1; TCNT<=AUTORELOAD ? 0 : TCNT+1
//   - else: TCNT<=TCNT+1 (wraps 16'hFFFF -> 16'h0000; the wrap itself sets no flag)
//   - EN=0: TCNT holds and MATCH is not set.
//  Simultaneous events:
//   - CPU write to TCNT in the same cycle as increment/reload: the write wins; no match evaluated that edge.
//   - W1C of MATCH in the same cycle as a new match: set wins, MATCH stays 1.
//   - Write to TCMP: the new value is used from the next edge on.
//   - Write to TCTL.EN=1: counting starts on the following edge.
// TESTING
//  1 Reset: assert reset 1 cycle -> ledr=0, timer_irq=0, read 0x181 returns 16'hFFFF, read_en=0 when mem_cmd=2'b10.
//  2 LED/SW: write 0x100 data 16'h12A5 -> ledr=8'hA5, read 0x100=16'h00A5.
//    sw=8'h3C -> read 0x140 still returns the old value for 1 edge, then =16'h003C after 2 edges.
//  3 Timer autoreload: TCMP=3, TCTL=16'h0003 -> TCNT sequence 0,1,2,3,0,1.
//    MATCH=1 and timer_irq=1 on the edge after TCNT==3.
//  4 Wrap/no-reload: TCNT=16'hFFFE, TCMP=5, TCTL=1 -> FFFF,0000,...,0005,0006; MATCH set only after 0005.
//  5 Collisions: W1C 0x183 in the same cycle as a match -> MATCH stays 1.
//    Write TCNT=16'h0100 during counting -> next read 16'h0100.
//  6 Decode: write 0x000 (RAM region) or 0x1FF -> no register changes; read 0x1FF -> read_en=1, read_data=0.

Source files
------------

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_responder
//  Description : Memory-mapped I/O responder for the upper half of the CPU
//                address space (mem_addr[8]==1). Provides an LED register,
//                a synchronized switch input and a 16-bit compare timer with
//                a sticky match flag that drives timer_irq.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_responder #(
    parameter int         LED_W  = 8,
    parameter int         SW_W   = 8,
    parameter int         SYNC_N = 2,
    parameter logic [1:0] MREAD  = 2'b01,
    parameter logic [1:0] MWRITE = 2'b00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [8:0]        mem_addr,
    input  logic [15:0]       write_data,
    output logic [15:0]       read_data,
    output logic              read_en,
    input  logic [SW_W-1:0]   sw,
    output logic [LED_W-1:0]  ledr,
    output logic              timer_irq
);

    // Register addresses (full 9-bit decode)
    localparam logic [8:0] c_addr_led   = 9'h100;
    localparam logic [8:0] c_addr_sw    = 9'h140;
    localparam logic [8:0] c_addr_tcnt  = 9'h180;
    localparam logic [8:0] c_addr_tcmp  = 9'h181;
    localparam logic [8:0] c_addr_tctl  = 9'h182;
    localparam logic [8:0] c_addr_tstat = 9'h183;

    // Architectural state
    logic [LED_W-1:0]             r_led;
    logic [SYNC_N-1:0][SW_W-1:0]  r_sync;
    logic [15:0]                  r_tcnt;
    logic [15:0]                  r_tcmp;
    logic                         r_en;
    logic                         r_autoreload;
    logic                         r_match;

    // Decode
    logic        w_sel;
    logic        w_wr;
    logic        w_wr_led;
    logic        w_wr_tcnt;
    logic        w_wr_tcmp;
    logic        w_wr_tctl;
    logic        w_clr_match;
    logic        w_hit;
    logic        w_set_match;
    logic [15:0] w_tcnt_next;
    logic [15:0] w_rd;

    assign w_sel       = mem_addr[8];
    assign w_wr        = (mem_cmd == MWRITE) && w_sel;
    assign read_en     = (mem_cmd == MREAD) && w_sel;
    assign w_wr_led    = w_wr && (mem_addr == c_addr_led);
    assign w_wr_tcnt   = w_wr && (mem_addr == c_addr_tcnt);
    assign w_wr_tcmp   = w_wr && (mem_addr == c_addr_tcmp);
    assign w_wr_tctl   = w_wr && (mem_addr == c_addr_tctl);
    assign w_clr_match = w_wr && (mem_addr == c_addr_tstat) && write_data[0];

    // A CPU write to TCNT suppresses both counting and match evaluation.
    assign w_hit       = (r_tcnt == r_tcmp);
    assign w_set_match = r_en && w_hit && !w_wr_tcnt;

    assign ledr      = r_led;
    assign timer_irq = r_match;

    // Next timer count: CPU write wins, otherwise reload on match or increment
    always_comb begin
        w_tcnt_next = r_tcnt;
        if (w_wr_tcnt) begin
            w_tcnt_next = write_data;
        end else if (r_en) begin
            if (w_hit && r_autoreload) begin
                w_tcnt_next = 16'h0000;
            end else begin
                w_tcnt_next = r_tcnt + 16'd1;
            end
        end
    end

    // LED register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led <= '0;
        end else if (w_wr_led) begin
            r_led <= write_data[LED_W-1:0];
        end
    end

    // First synchronizer stage samples the asynchronous switches
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync[0] <= '0;
        end else begin
            r_sync[0] <= sw;
        end
    end

    generate
        for (genvar i = 1; i < SYNC_N; i++) begin : g_sync
            // Remaining synchronizer stages shift the sampled value along
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync[i] <= '0;
                end else begin
                    r_sync[i] <= r_sync[i-1];
                end
            end
        end
    endgenerate

    // Timer count, compare and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt       <= 16'h0000;
            r_tcmp       <= 16'hFFFF;
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
        end else begin
            r_tcnt <= w_tcnt_next;
            if (w_wr_tcmp) begin
                r_tcmp <= write_data;
            end
            if (w_wr_tctl) begin
                r_en         <= write_data[0];
                r_autoreload <= write_data[1];
            end
        end
    end

    // Sticky match flag: a new match takes priority over a W1C in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_match <= 1'b0;
        end else if (w_set_match) begin
            r_match <= 1'b1;
        end else if (w_clr_match) begin
            r_match <= 1'b0;
        end
    end

    // Zero-latency read mux; unmapped addresses and idle cycles return zero
    always_comb begin
        w_rd = 16'h0000;
        case (mem_addr)
            c_addr_led:   w_rd[LED_W-1:0] = r_led;
            c_addr_sw:    w_rd[SW_W-1:0]  = r_sync[SYNC_N-1];
            c_addr_tcnt:  w_rd            = r_tcnt;
            c_addr_tcmp:  w_rd            = r_tcmp;
            c_addr_tctl:  w_rd[1:0]       = {r_autoreload, r_en};
            c_addr_tstat: w_rd[0]         = r_match;
            default:      w_rd            = 16'h0000;
        endcase
        read_data = read_en ? w_rd : 16'h0000;
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_responder
//  Description : Self-checking bench for mmio_responder. A behavioural model
//                tracks the register file from the register-map rules; the
//                outputs are compared against it every cycle, and directed
//                sequences pin known values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_responder;

    localparam int SYNC_N = 2;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_en;
    logic [7:0]  sw;
    logic [7:0]  ledr;
    logic        timer_irq;

    int n_chk  = 0;
    int n_pass = 0;

    mmio_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .read_en    (read_en),
        .sw         (sw),
        .ledr       (ledr),
        .timer_irq  (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid = 1'b0;
    logic [7:0]  m_led;
    logic [7:0]  m_sync [SYNC_N];
    logic [15:0] m_tcnt, m_tcmp;
    logic        m_en, m_ar, m_match;

    function automatic logic [15:0] model_rd(input logic [8:0] a);
        case (a)
            9'h100:  return {8'h00, m_led};
            9'h140:  return {8'h00, m_sync[SYNC_N-1]};
            9'h180:  return m_tcnt;
            9'h181:  return m_tcmp;
            9'h182:  return {14'h0, m_ar, m_en};
            9'h183:  return {15'h0, m_match};
            default: return 16'h0000;
        endcase
    endfunction

    // Model state advances on every rising edge from the inputs present before it
    always @(posedge clk) begin
        logic        wr;
        logic        hit;
        logic [15:0] cnt;
        if (reset) begin
            m_valid = 1'b1;
            m_led = 8'h00; m_tcnt = 16'h0000; m_tcmp = 16'hFFFF;
            m_en = 1'b0; m_ar = 1'b0; m_match = 1'b0;
            for (int i = 0; i < SYNC_N; i++) m_sync[i] = 8'h00;
        end else if (m_valid) begin
            wr  = (mem_cmd == 2'b00) && mem_addr[8];
            hit = 1'b0;
            cnt = m_tcnt;
            if (wr && mem_addr == 9'h180) begin
                cnt = write_data;
            end else if (m_en) begin
                hit = (m_tcnt == m_tcmp);
                cnt = (hit && m_ar) ? 16'h0000 : 16'((32'(m_tcnt) + 1) % 65536);
            end
            if (hit) m_match = 1'b1;
            else if (wr && mem_addr == 9'h183 && write_data[0]) m_match = 1'b0;
            m_tcnt = cnt;
            if (wr && mem_addr == 9'h181) m_tcmp = write_data;
            if (wr && mem_addr == 9'h182) begin m_en = write_data[0]; m_ar = write_data[1]; end
            if (wr && mem_addr == 9'h100) m_led = write_data[7:0];
            for (int i = SYNC_N - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = sw;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Compare DUT outputs against the model mid-cycle
    always @(negedge clk) begin
        logic e_en;
        if (m_valid) begin
            e_en = (mem_cmd == 2'b01) && mem_addr[8];
            chk("cyc_read_en", {31'h0, read_en}, {31'h0, e_en});
            chk("cyc_read_data", {16'h0, read_data}, {16'h0, e_en ? model_rd(mem_addr) : 16'h0000});
            chk("cyc_ledr", {24'h0, ledr}, {24'h0, m_led});
            chk("cyc_timer_irq", {31'h0, timer_irq}, {31'h0, m_match});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        mem_cmd = 2'b00; mem_addr = a; write_data = d;
        step();
        mem_cmd = 2'b10;
    endtask

    task automatic rd_chk(input logic [8:0] a, input logic [15:0] exp, input string name);
        mem_cmd = 2'b01; mem_addr = a;
        @(negedge clk);
        #1;
        chk(name, {16'h0, read_data}, {16'h0, exp});
    endtask

    int s3_cnt [6] = '{0, 1, 2, 3, 0, 1};
    int s3_irq [6] = '{0, 0, 0, 0, 1, 1};

    initial begin
        reset = 1'b1; mem_cmd = 2'b10; mem_addr = 9'h000; write_data = 16'h0; sw = 8'h00;
        step(); step();

        // Reset state
        reset = 1'b0; mem_cmd = 2'b10; mem_addr = 9'h100;
        @(negedge clk); #1;
        chk("rst_ledr", {24'h0, ledr}, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        chk("rst_read_en_nop", {31'h0, read_en}, 32'h0);
        chk("rst_read_data_nop", {16'h0, read_data}, 32'h0);
        rd_chk(9'h181, 16'hFFFF, "rst_tcmp");
        step();
        rd_chk(9'h140, 16'h0000, "rst_sw");
        step();

        // LED and switch synchronizer
        wr(9'h100, 16'h12A5);
        chk("led_out", {24'h0, ledr}, 32'hA5);
        rd_chk(9'h100, 16'h00A5, "led_read");
        step();
        sw = 8'h3C;
        rd_chk(9'h140, 16'h0000, "sw_0edge");
        step();
        rd_chk(9'h140, 16'h0000, "sw_1edge");
        step();
        rd_chk(9'h140, 16'h003C, "sw_2edge");
        step();

        // Timer with autoreload
        wr(9'h181, 16'd3);
        wr(9'h182, 16'h0003);
        for (int i = 0; i < 6; i++) begin
            rd_chk(9'h180, 16'(s3_cnt[i]), "ar_tcnt");
            chk("ar_irq", {31'h0, timer_irq}, 32'(s3_irq[i]));
            step();
        end

        // Wrap without reload
        wr(9'h182, 16'h0000);
        wr(9'h180, 16'hFFFE);
        wr(9'h181, 16'd5);
        wr(9'h183, 16'h0001);
        wr(9'h182, 16'h0001);
        for (int i = 0; i < 9; i++) begin
            rd_chk(9'h180, 16'((32'hFFFE + i) % 65536), "wrap_tcnt");
            chk("wrap_irq", {31'h0, timer_irq}, (i == 8) ? 32'h1 : 32'h0);
            step();
        end

        // W1C colliding with a new match; TCNT write during counting
        wr(9'h182, 16'h0000);
        wr(9'h180, 16'h0000);
        wr(9'h181, 16'd2);
        wr(9'h183, 16'h0001);
        chk("w1c_cleared", {31'h0, timer_irq}, 32'h0);
        wr(9'h182, 16'h0001);
        step(); step();
        wr(9'h183, 16'h0001);
        rd_chk(9'h183, 16'h0001, "w1c_vs_match");
        chk("w1c_vs_match_irq", {31'h0, timer_irq}, 32'h1);
        step();
        wr(9'h180, 16'h0100);
        rd_chk(9'h180, 16'h0100, "tcnt_write_wins");
        step();

        // Address decode
        wr(9'h000, 16'hFFFF);
        wr(9'h1FF, 16'hFFFF);
        chk("decode_ledr", {24'h0, ledr}, 32'hA5);
        rd_chk(9'h181, 16'h0002, "decode_tcmp");
        rd_chk(9'h1FF, 16'h0000, "decode_1ff_data");
        chk("decode_1ff_en", {31'h0, read_en}, 32'h1);
        mem_addr = 9'h0A0;
        @(negedge clk); #1;
        chk("decode_ram_en", {31'h0, read_en}, 32'h0);
        step();
        wr(9'h182, 16'h0000);

        // Randomized traffic checked by the per-cycle compare
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            mem_cmd  = 2'($urandom);
            case ($urandom_range(0, 7))
                0: mem_addr = 9'h100;
                1: mem_addr = 9'h140;
                2: mem_addr = 9'h180;
                3: mem_addr = 9'h181;
                4: mem_addr = 9'h182;
                5: mem_addr = 9'h183;
                default: mem_addr = 9'($urandom);
            endcase
            write_data = 16'($urandom);
            if (mem_addr == 9'h181 || (mem_addr == 9'h180 && $urandom_range(0, 1) == 0))
                write_data = 16'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
            step();
        end
        reset = 1'b0;
        mem_cmd = 2'b10;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
